// File: rtl/spi_master_mc.sv
// SPI master serialiser: programmable SCLK divider, all CPOL/CPHA modes, bit-order select,
// active-low chip selects that can be held across words, valid/ready command port.
module spi_master_mc #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned NUM_CS = 4,
   parameter int unsigned DIV_W  = 8,
   parameter int unsigned CS_W   = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
   input  logic              sys_clk,
   input  logic              sys_rst_n,
   input  logic              cfg_cpol,
   input  logic              cfg_cpha,
   input  logic              cfg_lsb_first,
   input  logic [DIV_W-1:0]  cfg_clk_div,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [DATA_W-1:0] cmd_data,
   input  logic [CS_W-1:0]   cmd_cs_sel,
   input  logic              cmd_hold_cs,
   input  logic              cmd_release,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_data,
   output logic              busy,
   output logic              spi_clk_o,
   output logic              spi_mosi_o,
   output logic [NUM_CS-1:0] spi_cs_o,
   input  logic              spi_miso_i
);

   localparam int unsigned EW = $clog2(2 * DATA_W);

   typedef enum logic [2:0] {StIdle, StSetup, StXfer, StHold, StTrail, StGap} state_e;

   state_e            state_q, state_d;
   logic [DIV_W-1:0]  cnt_q, cnt_d, div_q, div_d;
   logic [EW-1:0]     edge_q, edge_d;
   logic [DATA_W-1:0] tx_q, tx_d, rx_q, rx_d, rsp_data_q, rsp_data_d;
   logic [CS_W-1:0]   cs_sel_q, cs_sel_d;
   logic [NUM_CS-1:0] cs_q, cs_d;
   logic              hold_q, hold_d, cpol_q, cpol_d, cpha_q, cpha_d;
   logic              lsb_q, lsb_d, pend_q, pend_d;
   logic              sclk_q, sclk_d, mosi_q, mosi_d, rsp_valid_q, rsp_valid_d;

   logic              accept, tick, last_edge, same_cs, leading, enter_setup;
   logic [DATA_W-1:0] src_data;
   logic [CS_W-1:0]   src_sel;
   logic              src_cpha, src_lsb;

   assign cmd_ready = (state_q == StIdle) | (state_q == StHold);
   assign accept    = cmd_valid & cmd_ready;
   assign tick      = (cnt_q == div_q);
   assign last_edge = (edge_q == EW'(2 * DATA_W - 1));
   assign same_cs   = (cmd_cs_sel == cs_sel_q);
   assign leading   = ~edge_q[0];

   // A word entering SETUP comes either straight from the command port or from the
   // command parked during a CS-switch GAP.
   assign src_data = accept ? cmd_data      : tx_q;
   assign src_sel  = accept ? cmd_cs_sel    : cs_sel_q;
   assign src_cpha = accept ? cfg_cpha      : cpha_q;
   assign src_lsb  = accept ? cfg_lsb_first : lsb_q;

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle:  if (accept) state_d = StSetup;
         StSetup: if (tick) state_d = StXfer;
         StXfer:  if (tick && last_edge) state_d = hold_q ? StHold : StTrail;
         StHold: begin
            if (accept)           state_d = same_cs ? StSetup : StGap;
            else if (cmd_release) state_d = StTrail;
         end
         StTrail: if (tick) state_d = StGap;
         StGap:   if (tick) state_d = pend_q ? StSetup : StIdle;
         default: state_d = StIdle;
      endcase
   end

   assign enter_setup = (state_d == StSetup) && (state_q != StSetup);

   always_comb begin
      div_d       = div_q;
      edge_d      = edge_q;
      tx_d        = tx_q;
      rx_d        = rx_q;
      rsp_data_d  = rsp_data_q;
      cs_sel_d    = cs_sel_q;
      cs_d        = cs_q;
      hold_d      = hold_q;
      cpol_d      = cpol_q;
      cpha_d      = cpha_q;
      lsb_d       = lsb_q;
      pend_d      = pend_q;
      sclk_d      = sclk_q;
      mosi_d      = mosi_q;
      rsp_valid_d = 1'b0;
      cnt_d = (tick || state_q == StIdle || state_q == StHold) ? '0 : cnt_q + DIV_W'(1);

      if (accept) begin
         tx_d     = cmd_data;
         cs_sel_d = cmd_cs_sel;
         hold_d   = cmd_hold_cs;
         cpol_d   = cfg_cpol;
         cpha_d   = cfg_cpha;
         lsb_d    = cfg_lsb_first;
         div_d    = cfg_clk_div;
         pend_d   = (state_q == StHold) && !same_cs;
      end

      case (state_q)
         StIdle:  sclk_d = cfg_cpol;
         StSetup: sclk_d = cpol_q;
         StXfer: begin
            if (tick) begin
               edge_d = edge_q + EW'(1);
               sclk_d = ~sclk_q;
               if (leading ^ cpha_q) begin
                  rx_d = lsb_q ? {spi_miso_i, rx_q[DATA_W-1:1]} : {rx_q[DATA_W-2:0], spi_miso_i};
               end else begin
                  mosi_d = lsb_q ? tx_q[0] : tx_q[DATA_W-1];
                  tx_d   = lsb_q ? (tx_q >> 1) : (tx_q << 1);
               end
               if (last_edge) begin
                  rsp_valid_d = 1'b1;
                  rsp_data_d  = rx_d;
               end
            end
         end
         StHold:  if (accept && !same_cs) cs_d = '1;
         StTrail: if (tick) cs_d = '1;
         StGap: begin
            sclk_d = cpol_q;
            if (tick) pend_d = 1'b0;
         end
         default: ;
      endcase

      // CPHA=0 must present the first bit as soon as CS asserts.
      if (enter_setup) begin
         cs_d = '1;
         for (int i = 0; i < NUM_CS; i++) begin
            if (src_sel == CS_W'(i)) cs_d[i] = 1'b0;
         end
         edge_d = '0;
         rx_d   = '0;
         if (!src_cpha) begin
            mosi_d = src_lsb ? src_data[0] : src_data[DATA_W-1];
            tx_d   = src_lsb ? (src_data >> 1) : (src_data << 1);
         end else begin
            mosi_d = 1'b0;
            tx_d   = src_data;
         end
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         cnt_q       <= '0;
         div_q       <= '0;
         edge_q      <= '0;
         tx_q        <= '0;
         rx_q        <= '0;
         rsp_data_q  <= '0;
         cs_sel_q    <= '0;
         cs_q        <= '1;
         hold_q      <= 1'b0;
         cpol_q      <= 1'b0;
         cpha_q      <= 1'b0;
         lsb_q       <= 1'b0;
         pend_q      <= 1'b0;
         sclk_q      <= 1'b0;
         mosi_q      <= 1'b0;
         rsp_valid_q <= 1'b0;
      end else begin
         cnt_q       <= cnt_d;
         div_q       <= div_d;
         edge_q      <= edge_d;
         tx_q        <= tx_d;
         rx_q        <= rx_d;
         rsp_data_q  <= rsp_data_d;
         cs_sel_q    <= cs_sel_d;
         cs_q        <= cs_d;
         hold_q      <= hold_d;
         cpol_q      <= cpol_d;
         cpha_q      <= cpha_d;
         lsb_q       <= lsb_d;
         pend_q      <= pend_d;
         sclk_q      <= sclk_d;
         mosi_q      <= mosi_d;
         rsp_valid_q <= rsp_valid_d;
      end
   end

   assign busy       = (state_q != StIdle);
   assign rsp_valid  = rsp_valid_q;
   assign rsp_data   = rsp_data_q;
   assign spi_clk_o  = sclk_q;
   assign spi_mosi_o = mosi_q;
   assign spi_cs_o   = cs_q;

endmodule

// File: tb/tb_spi_master_mc.sv
// Directed bench for spi_master_mc: timing, all SPI modes against a slave model, bit order,
// held chip selects, release, async reset mid-word and config isolation.
module tb_spi_master_mc;

   logic       sys_clk, sys_rst_n;
   logic       cfg_cpol, cfg_cpha, cfg_lsb_first;
   logic [7:0] cfg_clk_div;
   logic       cmd_valid, cmd_ready, cmd_hold_cs, cmd_release;
   logic [7:0] cmd_data;
   logic [1:0] cmd_cs_sel;
   logic       rsp_valid, busy, spi_clk_o, spi_mosi_o, spi_miso_i;
   logic [7:0] rsp_data;
   logic [3:0] spi_cs_o;

   spi_master_mc #(.DATA_W(8), .NUM_CS(4), .DIV_W(8)) dut (
      .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .cfg_cpol(cfg_cpol), .cfg_cpha(cfg_cpha),
      .cfg_lsb_first(cfg_lsb_first), .cfg_clk_div(cfg_clk_div), .cmd_valid(cmd_valid),
      .cmd_ready(cmd_ready), .cmd_data(cmd_data), .cmd_cs_sel(cmd_cs_sel),
      .cmd_hold_cs(cmd_hold_cs), .cmd_release(cmd_release), .rsp_valid(rsp_valid),
      .rsp_data(rsp_data), .busy(busy), .spi_clk_o(spi_clk_o), .spi_mosi_o(spi_mosi_o),
      .spi_cs_o(spi_cs_o), .spi_miso_i(spi_miso_i)
   );

   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   int n_vec = 0;
   int n_err = 0;

   // Slave model: presents slave_pat MSB-first, changing on its shift edge per CPHA.
   logic       loop_en;
   logic [7:0] slave_pat;
   int         sl_edges = 0;
   int         sl_idx;
   logic       sl_prev = 1'b0;
   always @(negedge sys_clk) begin
      if (&spi_cs_o) sl_edges = 0;
      else if (spi_clk_o !== sl_prev) sl_edges++;
      sl_prev = spi_clk_o;
   end
   always_comb begin
      if (cfg_cpha) sl_idx = (sl_edges == 0) ? 0 : (sl_edges - 1) / 2;
      else sl_idx = sl_edges / 2;
   end
   assign spi_miso_i = loop_en ? spi_mosi_o
                               : ((sl_idx < 8) ? slave_pat[3'(7 - sl_idx)] : 1'b0);

   // Pin monitor, updated once per cycle on the falling edge.
   int         cyc = 0, rises = 0, rsp_cnt = 0, cs0_rises = 0, multi_low = 0;
   int         cs0_rise_cyc = 0, cs1_fall_cyc = 0;
   logic       m_prev_sclk = 1'b0;
   logic [3:0] m_prev_cs = 4'hF;
   logic [7:0] rsp_log[$];

   task automatic tick();
      @(negedge sys_clk);
      cyc++;
      if (spi_clk_o && !m_prev_sclk) rises++;
      if (rsp_valid) begin
         rsp_cnt++;
         rsp_log.push_back(rsp_data);
      end
      if (spi_cs_o[0] && !m_prev_cs[0]) begin
         cs0_rises++;
         cs0_rise_cyc = cyc;
      end
      if (!spi_cs_o[1] && m_prev_cs[1]) cs1_fall_cyc = cyc;
      if ($countones(~spi_cs_o) > 1) multi_low++;
      m_prev_sclk = spi_clk_o;
      m_prev_cs   = spi_cs_o;
   endtask

   int         r_rsp_n, r_cs_hi_n, r_ready_n, r_nbits;
   bit         r_timeout;
   logic [7:0] r_seq;
   logic [3:0] r_cs0;

   // Issue one command and watch until IDLE (or HOLD when hold=1); n counts cycles after accept.
   task automatic do_xfer(input logic [7:0] d, input logic [1:0] sel, input logic hold,
                          input int budget);
      logic prev, pol, pha;
      bit   done;
      pol = cfg_cpol; pha = cfg_cpha; prev = spi_clk_o; done = 0;
      r_rsp_n = -1; r_cs_hi_n = -1; r_ready_n = -1; r_nbits = 0; r_seq = '0; r_timeout = 0;
      cmd_data = d; cmd_cs_sel = sel; cmd_hold_cs = hold; cmd_valid = 1'b1;
      for (int n = 0; n < budget; n++) begin
         tick();
         if (n == 0) begin
            cmd_valid = 1'b0;
            r_cs0 = spi_cs_o;
         end
         if ((spi_clk_o !== prev) && ((spi_clk_o !== pol) != pha)) begin
            r_seq = {r_seq[6:0], spi_mosi_o};
            r_nbits++;
         end
         prev = spi_clk_o;
         if (rsp_valid && r_rsp_n < 0) r_rsp_n = n;
         if ((&spi_cs_o) && r_cs_hi_n < 0) r_cs_hi_n = n;
         if (cmd_ready && r_ready_n < 0) r_ready_n = n;
         if (hold ? (busy && cmd_ready) : !busy) begin
            done = 1;
            break;
         end
      end
      r_timeout = !done;
   endtask

   task automatic test_reset();
      n_vec++; if (spi_cs_o !== 4'hF) begin n_err++; $display("FAIL reset_cs: got %h want f", spi_cs_o); end
      n_vec++; if (spi_clk_o !== 1'b0) begin n_err++; $display("FAIL reset_sclk: got %b want 0", spi_clk_o); end
      n_vec++; if (spi_mosi_o !== 1'b0) begin n_err++; $display("FAIL reset_mosi: got %b want 0", spi_mosi_o); end
      n_vec++; if ({rsp_valid, rsp_data} !== 9'h0) begin n_err++; $display("FAIL reset_rsp: got %b/%h want 0/00", rsp_valid, rsp_data); end
      n_vec++; if ({busy, cmd_ready} !== 2'b01) begin n_err++; $display("FAIL reset_state: busy/ready got %b%b want 01", busy, cmd_ready); end
   endtask

   task automatic test_mode0_basic();
      int r0;
      r0 = rises;
      do_xfer(8'hA5, 2'd2, 1'b0, 100);
      n_vec++; if (r_timeout) begin n_err++; $display("FAIL m0_timeout: got 1 want 0"); end
      n_vec++; if (r_cs0 !== 4'b1011) begin n_err++; $display("FAIL m0_cs: got %b want 1011", r_cs0); end
      n_vec++; if (rises - r0 !== 8) begin n_err++; $display("FAIL m0_rises: got %0d want 8", rises - r0); end
      n_vec++; if (r_seq !== 8'hA5) begin n_err++; $display("FAIL m0_mosi: got %h want a5", r_seq); end
      n_vec++; if (rsp_data !== 8'hA5) begin n_err++; $display("FAIL m0_rsp: got %h want a5", rsp_data); end
      n_vec++; if (r_rsp_n !== 34) begin n_err++; $display("FAIL m0_rsp_time: got %0d want 34", r_rsp_n); end
      n_vec++; if (r_cs_hi_n !== 36) begin n_err++; $display("FAIL m0_cs_time: got %0d want 36", r_cs_hi_n); end
      n_vec++; if (r_ready_n !== 38) begin n_err++; $display("FAIL m0_ready_time: got %0d want 38", r_ready_n); end
   endtask

   task automatic test_modes();
      loop_en = 1'b0; slave_pat = 8'h3C;
      for (int m = 0; m < 4; m++) begin
         cfg_cpol = (m >= 2); cfg_cpha = (m % 2 == 1);
         tick(); tick();
         n_vec++; if (spi_clk_o !== cfg_cpol) begin n_err++; $display("FAIL mode%0d_idle_pre: got %b want %b", m, spi_clk_o, cfg_cpol); end
         do_xfer(8'h81, 2'd0, 1'b0, 100);
         n_vec++; if (r_timeout || r_nbits !== 8) begin n_err++; $display("FAIL mode%0d_bits: got %0d (timeout %0b) want 8", m, r_nbits, r_timeout); end
         n_vec++; if (rsp_data !== 8'h3C) begin n_err++; $display("FAIL mode%0d_rsp: got %h want 3c", m, rsp_data); end
         n_vec++; if (spi_clk_o !== cfg_cpol) begin n_err++; $display("FAIL mode%0d_idle_post: got %b want %b", m, spi_clk_o, cfg_cpol); end
      end
      cfg_cpol = 1'b0; cfg_cpha = 1'b0; loop_en = 1'b1;
      tick();
   endtask

   task automatic test_lsb_first();
      cfg_lsb_first = 1'b1;
      do_xfer(8'h01, 2'd0, 1'b0, 100);
      n_vec++; if (r_seq !== 8'h80 || r_nbits !== 8) begin n_err++; $display("FAIL lsb_mosi: got %h/%0d want 80/8", r_seq, r_nbits); end
      n_vec++; if (rsp_data !== 8'h01) begin n_err++; $display("FAIL lsb_rsp: got %h want 01", rsp_data); end
      cfg_lsb_first = 1'b0;
   endtask

   task automatic test_hold_same();
      int r0, k0, c0, q0;
      r0 = rises; k0 = rsp_cnt; c0 = cs0_rises; q0 = rsp_log.size();
      do_xfer(8'h11, 2'd0, 1'b1, 100);
      n_vec++; if (r_timeout) begin n_err++; $display("FAIL hold_reach: got timeout want HOLD"); end
      tick(); tick(); tick();
      do_xfer(8'h22, 2'd0, 1'b0, 100);
      n_vec++; if (rises - r0 !== 16) begin n_err++; $display("FAIL hold_rises: got %0d want 16", rises - r0); end
      n_vec++; if (rsp_cnt - k0 !== 2) begin n_err++; $display("FAIL hold_pulses: got %0d want 2", rsp_cnt - k0); end
      n_vec++; if (cs0_rises - c0 !== 1) begin n_err++; $display("FAIL hold_cs_glitch: cs0 rises got %0d want 1", cs0_rises - c0); end
      n_vec++; if (rsp_log.size() < q0 + 2 || rsp_log[q0] !== 8'h11 || rsp_log[q0+1] !== 8'h22) begin
         n_err++; $display("FAIL hold_data: got %0d words want 11,22", rsp_log.size() - q0); end
   endtask

   task automatic test_hold_switch();
      int k0, q0;
      k0 = rsp_cnt; q0 = rsp_log.size(); cs0_rise_cyc = 0; cs1_fall_cyc = 0;
      do_xfer(8'h11, 2'd0, 1'b1, 100);
      do_xfer(8'h33, 2'd1, 1'b0, 100);
      n_vec++; if (r_timeout) begin n_err++; $display("FAIL switch_timeout: got 1 want 0"); end
      n_vec++; if (cs1_fall_cyc - cs0_rise_cyc < 2) begin n_err++; $display("FAIL switch_gap: got %0d want >=2", cs1_fall_cyc - cs0_rise_cyc); end
      n_vec++; if (rsp_cnt - k0 !== 2 || rsp_log[q0+1] !== 8'h33) begin n_err++; $display("FAIL switch_rsp: got %0d pulses want 2 ending 33", rsp_cnt - k0); end
   endtask

   task automatic test_release();
      int k0, cs_n, rdy_n;
      do_xfer(8'h55, 2'd0, 1'b1, 100);
      k0 = rsp_cnt; cs_n = -1; rdy_n = -1;
      cmd_release = 1'b1;
      for (int n = 0; n < 20; n++) begin
         tick();
         cmd_release = 1'b0;
         if ((&spi_cs_o) && cs_n < 0) cs_n = n;
         if (cmd_ready && rdy_n < 0) rdy_n = n;
      end
      n_vec++; if (cs_n !== 2) begin n_err++; $display("FAIL release_cs: got %0d want 2", cs_n); end
      n_vec++; if (rdy_n !== 4 || busy !== 1'b0) begin n_err++; $display("FAIL release_idle: got %0d want 4", rdy_n); end
      n_vec++; if (rsp_cnt !== k0) begin n_err++; $display("FAIL release_rsp: got %0d pulses want 0", rsp_cnt - k0); end
   endtask

   task automatic test_reset_mid();
      int r0, k0;
      bit hit;
      r0 = rises; k0 = rsp_cnt; hit = 0;
      cmd_data = 8'h5A; cmd_cs_sel = 2'd3; cmd_hold_cs = 1'b0; cmd_valid = 1'b1;
      tick();
      cmd_valid = 1'b0;
      for (int n = 0; n < 100; n++) begin
         if (rises - r0 >= 4) begin
            hit = 1;
            break;
         end
         tick();
      end
      n_vec++; if (!hit || spi_cs_o !== 4'b0111) begin n_err++; $display("FAIL rstmid_reach: got %b want 0111", spi_cs_o); end
      sys_rst_n = 1'b0;
      #1;
      n_vec++; if (spi_cs_o !== 4'hF || spi_clk_o !== 1'b0) begin n_err++; $display("FAIL rstmid_async: got cs %h sclk %b want f 0", spi_cs_o, spi_clk_o); end
      tick(); tick();
      n_vec++; if (rsp_cnt !== k0 || rsp_data !== 8'h00) begin n_err++; $display("FAIL rstmid_rsp: got %0d pulses data %h want 0 00", rsp_cnt - k0, rsp_data); end
      sys_rst_n = 1'b1;
      tick(); tick();
      do_xfer(8'h5A, 2'd3, 1'b0, 100);
      n_vec++; if (rsp_data !== 8'h5A || r_rsp_n !== 34) begin n_err++; $display("FAIL rstmid_after: got %h at %0d want 5a at 34", rsp_data, r_rsp_n); end
   endtask

   task automatic test_div0();
      cfg_clk_div = 8'd0;
      tick();
      do_xfer(8'hC3, 2'd1, 1'b0, 60);
      n_vec++; if (rsp_data !== 8'hC3 || r_seq !== 8'hC3) begin n_err++; $display("FAIL div0_data: got %h mosi %h want c3", rsp_data, r_seq); end
      n_vec++; if (r_rsp_n !== 17 || r_cs_hi_n !== 18 || r_ready_n !== 19) begin
         n_err++; $display("FAIL div0_timing: got %0d/%0d/%0d want 17/18/19", r_rsp_n, r_cs_hi_n, r_ready_n); end
      cfg_clk_div = 8'd1;
      tick();
   endtask

   task automatic test_cpol_change();
      int r0;
      bit done;
      r0 = rises; done = 0;
      cmd_data = 8'h96; cmd_cs_sel = 2'd0; cmd_hold_cs = 1'b0; cmd_valid = 1'b1;
      tick();
      cmd_valid = 1'b0;
      for (int n = 0; n < 100; n++) begin
         tick();
         if (rises - r0 == 3) cfg_cpol = 1'b1;
         if (!busy) begin
            done = 1;
            break;
         end
      end
      n_vec++; if (!done || rises - r0 !== 8) begin n_err++; $display("FAIL cpol_rises: got %0d want 8", rises - r0); end
      n_vec++; if (rsp_data !== 8'h96) begin n_err++; $display("FAIL cpol_rsp: got %h want 96", rsp_data); end
      n_vec++; if (spi_clk_o !== 1'b0) begin n_err++; $display("FAIL cpol_end_level: got %b want 0", spi_clk_o); end
      tick();
      n_vec++; if (spi_clk_o !== 1'b1) begin n_err++; $display("FAIL cpol_idle_follow: got %b want 1", spi_clk_o); end
      cfg_cpol = 1'b0;
      tick();
   endtask

   initial begin
      sys_rst_n = 1'b0; cfg_cpol = 1'b0; cfg_cpha = 1'b0; cfg_lsb_first = 1'b0;
      cfg_clk_div = 8'd1; cmd_valid = 1'b0; cmd_data = '0; cmd_cs_sel = '0;
      cmd_hold_cs = 1'b0; cmd_release = 1'b0; loop_en = 1'b1; slave_pat = 8'h00;
      tick(); tick();
      test_reset();
      sys_rst_n = 1'b1;
      tick(); tick();
      test_mode0_basic();
      test_modes();
      test_lsb_first();
      test_hold_same();
      test_hold_switch();
      test_release();
      test_reset_mid();
      test_div0();
      test_cpol_change();
      n_vec++; if (multi_low !== 0) begin n_err++; $display("FAIL one_cs_low: got %0d cycles with >1 CS low want 0", multi_low); end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/spi_master_mc.md
Name: spi_master_mc

Overview:
Synthesisable, parametrised SPI master that replaces the per-cycle software-driven pin model with a hardware serialiser. It runs on sys_clk and has a programmable SCLK divider, all four CPOL/CPHA modes, MSB/LSB-first ordering and NUM_CS active-low chip selects. It offers a valid/ready command port and a one-cycle response pulse. It sits between a host-side command source (bus bridge or socket-fed testbench driver) and the SPI pins.

Parameters:
DATA_W, 8, bits per SPI word (2..32)
NUM_CS, 4, number of chip-select lines (1..16)
DIV_W, 8, width of the clock-divider config field
CS_W, $clog2(NUM_CS) (min 1), width of cmd_cs_sel

Ports:
sys_clk  in  1  system clock
sys_rst_n  in  1  asynchronous active-low reset
cfg_cpol  in  1  SCLK idle level
cfg_cpha  in  1  0: sample on leading edge; 1: sample on trailing edge
cfg_lsb_first  in  1  bit order
cfg_clk_div  in  DIV_W  half-period H = cfg_clk_div+1 sys_clk cycles
cmd_valid  in  1  command request
cmd_ready  out  1  block can accept a command
cmd_data  in  DATA_W  word to transmit
cmd_cs_sel  in  CS_W  target chip select
cmd_hold_cs  in  1  keep CS asserted after this word
cmd_release  in  1  drop a held CS without a new word
rsp_valid  out  1  one-cycle pulse, word received
rsp_data  out  DATA_W  received word, held until the next rsp_valid
busy  out  1  state != IDLE
spi_clk_o  out  1  SCLK
spi_mosi_o  out  1  MOSI
spi_cs_o  out  NUM_CS  active-low chip selects
spi_miso_i  in  1  MISO; sampled directly, no synchroniser

Behaviour:
- Reset (async, immediate on sys_rst_n=0):
  - State IDLE.
  - spi_cs_o all ones; spi_clk_o=0; spi_mosi_o=0.
  - rsp_valid=0; rsp_data=0.
  - All internal counters and shift registers 0.
  - Reset asserted mid-transfer aborts it. CS goes high in the same timestep, and no rsp_valid is issued.
- In IDLE, spi_clk_o follows cfg_cpol, registered every cycle.
- cmd_ready = (state==IDLE) | (state==HOLD), decoded from the state register.
- Accept happens when cmd_valid & cmd_ready. At accept the block latches cmd_data, cs_sel, hold, cpol, cpha, lsb_first and div. Later config changes have no effect until the next accept.
- States and transitions:
  - IDLE → SETUP on accept. The selected CS goes low on the next cycle.
    - CPHA=0: first data bit is driven on MOSI on the same cycle CS goes low.
  - SETUP: lasts H cycles (CS lead time), then → XFER.
  - XFER: 2*DATA_W half-periods of H cycles each. SCLK toggles at the end of each half-period.
    - CPHA=0: MOSI shifts on trailing edges; MISO is sampled on leading edges.
    - CPHA=1: MOSI shifts on leading edges; MISO is sampled on trailing edges.
    - After the final edge, SCLK is back at cpol.
  - End of XFER: rsp_valid pulses for exactly 1 cycle, H*(2*DATA_W+1) cycles after accept. rsp_data updates in the same cycle. There is no response backpressure.
  - After XFER: → HOLD if hold=1, else → TRAIL.
  - TRAIL: H cycles with CS still low, then CS goes high → GAP.
  - GAP: H cycles with all CS high, cmd_ready=0, then → IDLE.
  - Timing without hold: CS high at accept+H*(2*DATA_W+2); cmd_ready high again at accept+H*(2*DATA_W+3).
  - HOLD: CS stays low and SCLK stays at cpol.
    - Accept with the same cs_sel → SETUP without a CS glitch.
    - Accept with a different cs_sel → the command is latched, old CS goes high, GAP, then the new CS asserts → SETUP.
    - cmd_release=1 with no accept → TRAIL.
    - Accept together with cmd_release in the same cycle: the accept wins and release is ignored.
- Word ordering: LSB-first transmits cmd_data[0] first and places the first received bit in rsp_data[0]. MSB-first is the mirror image.
- cmd_cs_sel >= NUM_CS: the word is clocked normally with no CS asserted, and rsp_data is still returned.
- cfg_clk_div=0 gives H=1, i.e. SCLK = sys_clk/2. Maximum divider is 2^DIV_W.
- Only one CS is ever low at a time.

Test Plan:
- Mode 0, DATA_W=8, div=1 (H=2), MSB-first, cmd 0xA5 to cs 2, MISO loopback from MOSI:
  - spi_cs_o=4'b1011 during the transfer.
  - 8 rising edges; MOSI samples 1,0,1,0,0,1,0,1.
  - rsp_data=0xA5 with rsp_valid at accept+34.
  - CS high at accept+36; ready again at accept+38.
- All four CPOL/CPHA modes with MISO driven from the slave pattern 0x3C on the correct shift edge → rsp_data=0x3C in each mode. SCLK idles at cpol before and after.
- LSB-first, cmd 0x01 → first MOSI bit is 1 and the remaining 7 are 0. With loopback, rsp_data=0x01.
- Hold sequence:
  - cmd 0x11 with hold=1 on cs 0, then cmd 0x22 on cs 0 with hold=0 → CS0 stays low continuously across both words, 16 SCLK cycles total, two rsp_valid pulses.
  - Repeat with the second word on cs 1 → CS0 high for ≥H cycles before CS1 goes low.
- In HOLD, pulse cmd_release → CS goes high after H cycles, then IDLE after another H. No rsp_valid.
- Reset and config edge cases:
  - Assert sys_rst_n=0 at bit 4 of a transfer → CS all high and SCLK=0 immediately; no rsp_valid; a new command after reset completes correctly.
  - Change cfg_cpol mid-word → the current word is unaffected.
